read_rdata_buffer: RTL and testbench

Read-data reorder buffer placed between the crossbar's slave-side read port and the master return path. It collects a burst of up to DEPTH read requests, tagging each with its originating master ID. It then captures the slave's rdata beats in arrival order and returns them to the masters one beat per handshake, in request order. The block sequences IDLE → COLLECT → FILL → DRAIN → CLEAR, the same phase cadence as the slave read controller it runs alongside.

---
 rtl/read_rdata_buffer.sv | 140 ++++++++++++++
 tb/tb_read_rdata_buffer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/read_rdata_buffer.sv
// Read-data reorder buffer: collects up to DEPTH read requests, captures the slave beats, returns them in request order.
// Latency: first beat valid the cycle after the last rdata beat is captured; then 1 beat/cycle, plus 1 CLEAR cycle.
// Backpressure: master_rready low holds the return beat; req_ready is decoded from state only. Optional READ_BUF_TIMEOUT_EN.
module read_rdata_buffer #(
    parameter int DATA_W  = 32,
    parameter int MID_W   = 2,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst_in,
    input  logic              slave_req,
    input  logic              slave_cmd,
    input  logic [MID_W-1:0]  slave_id,
    output logic              req_ready,
    input  logic              slave_rvalid,
    input  logic [DATA_W-1:0] slave_rdata,
    output logic              master_rvalid,
    input  logic              master_rready,
    output logic [MID_W-1:0]  master_rid,
    output logic [DATA_W-1:0] master_rdata,
    output logic              busy,
    output logic              err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    if (DEPTH < 2 || DEPTH > 8 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1 || TIMEOUT > 255)
    begin : g_param_check
        $error("read_rdata_buffer: DEPTH must be a power of two in 2..8, TIMEOUT in 1..255");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_FILL,
        S_DRAIN,
        S_CLEAR
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]     count;
    logic [CW-1:0]     fill_ptr;
    logic [CW-1:0]     rd_ptr;
    logic [MID_W-1:0]  id_mem   [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic accept;
    logic fill_beat;
    logic xfer;
    logic timeout_hit;

    assign req_ready     = (state == S_IDLE) || ((state == S_COLLECT) && (count < FULL));
    assign accept        = slave_req && !slave_cmd && req_ready;
    assign fill_beat     = (state == S_FILL) && slave_rvalid;
    assign master_rvalid = (state == S_DRAIN);
    assign xfer          = master_rvalid && master_rready;
    assign master_rid    = master_rvalid ? id_mem[rd_ptr[AW-1:0]]   : '0;
    assign master_rdata  = master_rvalid ? data_mem[rd_ptr[AW-1:0]] : '0;
    assign busy          = (state != S_IDLE);

`ifdef READ_BUF_TIMEOUT_EN
    logic [7:0] idle_cnt;

    // An accepted request restarts the idle window, so it wins over a same-cycle expiry.
    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            idle_cnt <= '0;
        end else if (accept || state == S_CLEAR) begin
            idle_cnt <= '0;
        end else if (state == S_COLLECT) begin
            idle_cnt <= idle_cnt + 8'd1;
        end
    end

    assign timeout_hit = (state == S_COLLECT) && !accept && (count != '0) &&
                         (idle_cnt == 8'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (accept) state_nxt = S_COLLECT;
            S_COLLECT: if ((accept && count == LAST) || timeout_hit) state_nxt = S_FILL;
            S_FILL:    if (fill_beat && (fill_ptr + 1'b1) == count) state_nxt = S_DRAIN;
            S_DRAIN:   if (xfer && (rd_ptr + 1'b1) == count) state_nxt = S_CLEAR;
            S_CLEAR:   state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            count    <= '0;
            fill_ptr <= '0;
            rd_ptr   <= '0;
            err      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                id_mem[i]   <= '0;
                data_mem[i] <= '0;
            end
        end else begin
            // Stray beats outside FILL are dropped but flagged until reset.
            if (slave_rvalid && state != S_FILL) begin
                err <= 1'b1;
            end
            if (accept) begin
                id_mem[count[AW-1:0]] <= slave_id;
                count                 <= count + 1'b1;
            end
            if (fill_beat) begin
                data_mem[fill_ptr[AW-1:0]] <= slave_rdata;
                fill_ptr                   <= fill_ptr + 1'b1;
            end
            if (xfer) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (state == S_CLEAR) begin
                count    <= '0;
                fill_ptr <= '0;
                rd_ptr   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_read_rdata_buffer.sv
// Bench for read_rdata_buffer: cycle table for a full burst, hand sequences for corner cases, randomized bursts vs a queue model.
module tb_read_rdata_buffer;

    localparam int DW = 32;
    localparam int MW = 2;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          rst_in;
    logic          slave_req;
    logic          slave_cmd;
    logic [MW-1:0] slave_id;
    logic          req_ready;
    logic          slave_rvalid;
    logic [DW-1:0] slave_rdata;
    logic          master_rvalid;
    logic          master_rready;
    logic [MW-1:0] master_rid;
    logic [DW-1:0] master_rdata;
    logic          busy;
    logic          err;

    int n_vec = 0;
    int n_err = 0;

    read_rdata_buffer #(.DATA_W(DW), .MID_W(MW), .DEPTH(DP), .TIMEOUT(8)) dut (
        .clk          (clk),
        .rst_in       (rst_in),
        .slave_req    (slave_req),
        .slave_cmd    (slave_cmd),
        .slave_id     (slave_id),
        .req_ready    (req_ready),
        .slave_rvalid (slave_rvalid),
        .slave_rdata  (slave_rdata),
        .master_rvalid(master_rvalid),
        .master_rready(master_rready),
        .master_rid   (master_rid),
        .master_rdata (master_rdata),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          req;
        logic [MW-1:0] id;
        logic          rv;
        logic [DW-1:0] rd;
        logic          rr;
        logic          e_rdy;
        logic          e_mv;
        logic [MW-1:0] e_rid;
        logic [DW-1:0] e_rdat;
        logic          e_busy;
    } vec_t;

    function automatic vec_t mk(input logic req, input logic [MW-1:0] id, input logic rv,
                                input logic [DW-1:0] rd, input logic rr, input logic e_rdy,
                                input logic e_mv, input logic [MW-1:0] e_rid,
                                input logic [DW-1:0] e_rdat, input logic e_busy);
        vec_t v;
        v.req = req; v.id = id; v.rv = rv; v.rd = rd; v.rr = rr;
        v.e_rdy = e_rdy; v.e_mv = e_mv; v.e_rid = e_rid; v.e_rdat = e_rdat; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: cycle budget expired (t=%0t)", name, $time);
    endtask

    task automatic idle_in();
        slave_req     = 1'b0;
        slave_cmd     = 1'b0;
        slave_id      = '0;
        slave_rvalid  = 1'b0;
        slave_rdata   = '0;
        master_rready = 1'b0;
    endtask

    task automatic send_reads(input logic [7:0] ids, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("collect_rdy", req_ready, 1);
            idle_in();
            slave_req = 1'b1;
            slave_id  = ids[2*k +: 2];
        end
    endtask

    // A read request is poked alongside each beat; it must be refused while filling.
    task automatic send_data(input logic [31:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("fill_rdy", req_ready, 0);
            idle_in();
            slave_req    = 1'b1;
            slave_id     = 2'd3;
            slave_rvalid = 1'b1;
            slave_rdata  = base + 32'(k);
        end
    endtask

    task automatic drain(input logic [7:0] ids, input logic [31:0] base, input int n,
                         input int stall_beat, input int stall_len, input int stop);
        int beat   = 0;
        int stalls = 0;
        int cyc    = 0;
        while (beat < stop && cyc < 100) begin
            @(negedge clk);
            cyc++;
            chk("drain_vld", master_rvalid, 1);
            chk("drain_rid", master_rid, 32'(ids[2*beat +: 2]));
            chk("drain_dat", master_rdata, base + 32'(beat));
            chk("drain_rdy", req_ready, 0);
            idle_in();
            slave_req = 1'b1;
            slave_id  = 2'd3;
            if (beat == stall_beat && stalls < stall_len) begin
                stalls++;
            end else begin
                master_rready = 1'b1;
                beat++;
            end
        end
        if (cyc >= 100) bound_fail("drain_budget");
        if (stop == n) begin
            @(negedge clk);
            chk("clear_vld", master_rvalid, 0);
            chk("clear_rdy", req_ready, 0);
            chk("clear_busy", busy, 1);
            idle_in();
            @(negedge clk);
            chk("idle_rdy", req_ready, 1);
            chk("idle_busy", busy, 0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t tbl[14];
        tbl[0]  = mk(1'b1, 2'd2, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 2'd0, 32'h0,  1'b0);
        tbl[1]  = mk(1'b1, 2'd0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 2'd0, 32'h0,  1'b1);
        tbl[2]  = mk(1'b1, 2'd3, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 2'd0, 32'h0,  1'b1);
        tbl[3]  = mk(1'b1, 2'd1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 2'd0, 32'h0,  1'b1);
        tbl[4]  = mk(1'b0, 2'd0, 1'b1, 32'hA0, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0,  1'b1);
        tbl[5]  = mk(1'b0, 2'd0, 1'b1, 32'hA1, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0,  1'b1);
        tbl[6]  = mk(1'b0, 2'd0, 1'b1, 32'hA2, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0,  1'b1);
        tbl[7]  = mk(1'b0, 2'd0, 1'b1, 32'hA3, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0,  1'b1);
        tbl[8]  = mk(1'b0, 2'd0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 2'd2, 32'hA0, 1'b1);
        tbl[9]  = mk(1'b0, 2'd0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 2'd0, 32'hA1, 1'b1);
        tbl[10] = mk(1'b0, 2'd0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 2'd3, 32'hA2, 1'b1);
        tbl[11] = mk(1'b0, 2'd0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 2'd1, 32'hA3, 1'b1);
        tbl[12] = mk(1'b0, 2'd0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 2'd0, 32'h0,  1'b1);
        tbl[13] = mk(1'b0, 2'd0, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 2'd0, 32'h0,  1'b0);

        rst_in = 1'b1;
        idle_in();
        repeat (2) @(negedge clk);
        chk("rst_rdy", req_ready, 1);
        chk("rst_mv", master_rvalid, 0);
        chk("rst_rid", master_rid, 0);
        chk("rst_rdat", master_rdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        rst_in = 1'b0;

        // Full burst, cycle by cycle.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            chk($sformatf("tbl%0d_rdy", i), req_ready, 32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_mv", i), master_rvalid, 32'(tbl[i].e_mv));
            chk($sformatf("tbl%0d_rid", i), master_rid, 32'(tbl[i].e_rid));
            chk($sformatf("tbl%0d_rdat", i), master_rdata, tbl[i].e_rdat);
            chk($sformatf("tbl%0d_busy", i), busy, 32'(tbl[i].e_busy));
            idle_in();
            slave_req     = tbl[i].req;
            slave_id      = tbl[i].id;
            slave_rvalid  = tbl[i].rv;
            slave_rdata   = tbl[i].rd;
            master_rready = tbl[i].rr;
        end
        chk("tbl_err", err, 0);

        // Backpressure on beat 1 for 3 cycles.
        send_reads(8'b01_11_00_10, 4);
        send_data(32'hB0, 4);
        drain(8'b01_11_00_10, 32'hB0, 4, 1, 3, 4);

        // Writes are ignored; a stray beat in IDLE sets a sticky err.
        @(negedge clk);
        idle_in();
        slave_req = 1'b1; slave_cmd = 1'b1; slave_id = 2'd1;
        @(negedge clk);
        @(negedge clk);
        chk("wr_busy", busy, 0);
        chk("wr_rdy", req_ready, 1);
        idle_in();
        slave_rvalid = 1'b1; slave_rdata = 32'hDEAD;
        @(negedge clk);
        idle_in();
        chk("stray_err", err, 1);
        chk("stray_busy", busy, 0);
        send_reads(8'b11_10_01_00, 4);
        send_data(32'hE0, 4);
        drain(8'b11_10_01_00, 32'hE0, 4, -1, 0, 4);
        chk("err_sticky", err, 1);
        @(negedge clk);
        rst_in = 1'b1;
        @(negedge clk);
        chk("err_cleared", err, 0);
        rst_in = 1'b0;

        // Partial burst: 2 reads then idle.
        send_reads(8'b00_00_10_01, 2);
`ifdef READ_BUF_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("to_wait_rdy", req_ready, 1);
            chk("to_wait_busy", busy, 1);
            idle_in();
        end
        send_data(32'h50, 2);
        drain(8'b00_00_10_01, 32'h50, 2, -1, 0, 2);
`else
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("no_to_rdy", req_ready, 1);
            chk("no_to_mv", master_rvalid, 0);
            idle_in();
        end
        rst_in = 1'b1;
        @(negedge clk);
        rst_in = 1'b0;
`endif

        // Reset asserted mid-DRAIN after the first beat.
        send_reads(8'b00_01_10_11, 4);
        send_data(32'hC0, 4);
        drain(8'b00_01_10_11, 32'hC0, 4, -1, 0, 1);
        @(posedge clk);
        #2;
        chk("mid_pre_rid", master_rid, 2);
        chk("mid_pre_dat", master_rdata, 32'hC1);
        rst_in = 1'b1;
        #1;
        chk("mid_rst_mv", master_rvalid, 0);
        chk("mid_rst_rid", master_rid, 0);
        chk("mid_rst_dat", master_rdata, 0);
        chk("mid_rst_busy", busy, 0);
        @(negedge clk);
        idle_in();
        rst_in = 1'b0;
        send_reads(8'b10_01_11_00, 4);
        send_data(32'hD0, 4);
        drain(8'b10_01_11_00, 32'hD0, 4, -1, 0, 4);

        // Randomized bursts against a queue model of request order.
        for (int b = 0; b < 20; b++) begin
            logic [MW-1:0] q_id[$];
            logic [DW-1:0] q_dat[$];
            int gap = 0;
            int n   = 0;
            int cyc = 0;
            while (q_id.size() < DP) begin
                int r;
                @(negedge clk);
                chk("rnd_col_rdy", req_ready, 1);
                chk("rnd_col_busy", busy, 32'(q_id.size() != 0));
                idle_in();
                r = (gap >= 3) ? 2 : int'($urandom_range(0, 3));
                slave_id = MW'($urandom);
                if (r >= 2) begin
                    slave_req = 1'b1;
                    q_id.push_back(slave_id);
                    gap = 0;
                end else begin
                    slave_req = (r == 1);
                    slave_cmd = 1'b1;
                    gap++;
                end
            end
            while (n < DP && cyc < 200) begin
                @(negedge clk);
                cyc++;
                chk("rnd_fill_rdy", req_ready, 0);
                chk("rnd_fill_mv", master_rvalid, 0);
                idle_in();
                slave_req = $urandom_range(0, 1) != 0;
                slave_id  = MW'($urandom);
                if ($urandom_range(0, 1) != 0) begin
                    slave_rvalid = 1'b1;
                    slave_rdata  = $urandom;
                    q_dat.push_back(slave_rdata);
                    n++;
                end
            end
            if (cyc >= 200) bound_fail("rnd_fill_budget");
            cyc = 0;
            while (q_dat.size() > 0 && cyc < 200) begin
                @(negedge clk);
                cyc++;
                chk("rnd_mv", master_rvalid, 1);
                chk("rnd_rid", master_rid, 32'(q_id[0]));
                chk("rnd_dat", master_rdata, q_dat[0]);
                idle_in();
                master_rready = $urandom_range(0, 1) != 0;
                if (master_rready) begin
                    void'(q_id.pop_front());
                    void'(q_dat.pop_front());
                end
            end
            if (cyc >= 200) bound_fail("rnd_drain_budget");
            @(negedge clk);
            chk("rnd_clear_mv", master_rvalid, 0);
            chk("rnd_clear_rdy", req_ready, 0);
            idle_in();
        end
        @(negedge clk);
        chk("rnd_err", err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
